moore_nonoverlap_seq_detector: RTL and testbench
================================================

# moore_nonoverlap_seq_detector

Moore-style serial bit-pattern detector for module `moore_nonoverlap`. It samples one input bit per clock and raises `o_seq_detected` for one cycle after a complete, non-overlapping occurrence of a configurable pattern. Bits of a detected occurrence are never reused for the next match. It sits directly on a serial data line as a framing/marker detector feeding control logic.

## Interface
- `SEQ_LEN`, default 4: pattern length in bits; legal range 2..16.
- `SEQ`, default 4'b1100: pattern, width `SEQ_LEN`; MSB is the first bit received.
- `i_clk` input 1: clock; all state updates on rising edge.
- `i_reset` input 1: one clock; reset is synchronous and active-high. While high at a rising edge, the state returns to IDLE.
- `i_x` input 1: serial data bit, sampled on each rising edge.
- `o_seq_detected` output 1: high for the one cycle in which the FSM is in DETECT.

## Operation
- States are S0 (IDLE, 0 bits matched), S1..S(SEQ_LEN-1) (k leading pattern bits matched), and S_N (DETECT). Total SEQ_LEN+1 states; encoding is free, binary is recommended.
- Output is a function of state only (Moore): `o_seq_detected` = 1 in S_N, else 0. There is no combinational path from `i_x` to the output.
- Transition from Sk, k<SEQ_LEN, on bit x:
  - If x equals pattern bit k (0-based from MSB), go to S(k+1).
  - Otherwise go to Sj. Sj is the longest proper suffix of (matched k bits followed by x) that is also a pattern prefix (KMP failure rule), so no start position inside a partial match is lost.
- Transition from S_N on bit x is identical to the transition from S0: S1 if x equals pattern bit 0, else S0. This is the non-overlap rule: the tail of a completed match never counts toward the next one.
- Transition tables are derived from `SEQ` at elaboration. No runtime configuration.
- X or Z on `i_x` is not defined behaviour. The bench drives only 0/1 outside reset.

## Timing
- Reset: the synchronous `i_reset` sampled high puts the state in S0 and drives `o_seq_detected` to 0 from the following cycle. `i_reset` has priority over `i_x`.
- Reset asserted mid-match discards all partial progress. The first bit counted is the one sampled at the first edge with `i_reset` low.
- Latency: when the last pattern bit is sampled at edge N, `o_seq_detected` is high from edge N until edge N+1, exactly one cycle.
- Back-to-back detections are separated by at least SEQ_LEN cycles. The output never stays high for two consecutive cycles.
- Output and state are undefined before the first reset edge. They are deterministic afterwards.

## Test plan
- Reset: hold `i_reset`=1 for 2 edges with arbitrary `i_x`, then check `o_seq_detected`=0. Release reset and drive 0,0,0, then check the output stays 0.
- Basic match with default `SEQ`=1100: drive 1,1,0,0. The output is 1 for exactly the cycle after the 4th edge, then 0.
- Partial-match recovery with default: drive 1,1,1,0,0. The extra 1 keeps the FSM in S2 and exactly one detection follows the final 0. Drive 1,0,1,1,0,0: exactly one detection, after the last bit.
- Non-overlap with override `SEQ`=4'b1010: drive 1,0,1,0,1,0. There is one detection after bit 4 and none after bit 6. Then drive 1,0,1,0,1,0,1,0. There are detections after bits 4 and 8 only.
- Reset mid-match with default: drive 1,1,0, assert `i_reset` for 1 edge, then drive 0. There is no detection. Then drive 1,1,0,0: one detection.
- Continuous stream with default: drive 1,1,0,0 repeated 3 times. There are three one-cycle pulses, spaced 4 cycles apart.

Source files
------------

// File: rtl/moore_nonoverlap_seq_detector.sv
// Moore serial pattern detector with non-overlapping matches.
// One input bit is sampled per rising edge. o_seq_detected is high for the
// single cycle the FSM spends in the DETECT state. Partial-match recovery
// follows the KMP failure rule. Every transition is computed from SEQ at
// elaboration time, so the fabric holds two small constant lookup tables.
module moore_nonoverlap_seq_detector #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1100
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_x,
  output logic o_seq_detected
);

  // States 0..SEQ_LEN-1 count matched leading bits. State SEQ_LEN is DETECT.
  localparam int              SW     = $clog2(SEQ_LEN + 1);
  localparam int              NSLOT  = 2 ** SW;
  localparam logic [SW-1:0]   S_IDLE = '0;
  localparam logic [SW-1:0]   S_DET  = SW'(SEQ_LEN);

  // Returns bit i of the pattern, counting from the first bit received (MSB).
  function automatic logic pat_bit(input int i);
    return SEQ[SEQ_LEN-1-i];
  endfunction

  // Finds the next state from "k bits matched" when bit x arrives. The result
  // is the longest suffix of (pattern[0..k-1], x) that is also a pattern
  // prefix. A full extension gives k+1, which is DETECT when k = SEQ_LEN-1.
  function automatic int kmp_next(input int k, input logic x);
    int   best;
    int   m;
    logic ok;
    logic s_bit;
    best = 0;
    for (int j = 1; j <= SEQ_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < SEQ_LEN; i++) begin
          if (i < j) begin
            m     = k + 1 - j + i;
            s_bit = (m < k) ? pat_bit(m) : x;
            if (s_bit != pat_bit(i)) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Transition tables are indexed by the current state. DETECT reuses the
  // IDLE row, so the tail of a completed match never seeds the next one.
  // Encodings above DETECT cannot be reached. They fall back to IDLE.
  logic [SW-1:0] nxt_on0 [NSLOT];
  logic [SW-1:0] nxt_on1 [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_tbl
    localparam int ROW = (g == SEQ_LEN) ? 0 : g;
    localparam int N0  = (g > SEQ_LEN) ? 0 : kmp_next(ROW, 1'b0);
    localparam int N1  = (g > SEQ_LEN) ? 0 : kmp_next(ROW, 1'b1);
    assign nxt_on0[g] = SW'(N0);
    assign nxt_on1[g] = SW'(N1);
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_nxt;

  // State register. A synchronous reset takes priority over the data bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state lookup driven by the sampled serial bit.
  always_comb begin
    state_nxt = state_q;
    if (i_x) begin
      state_nxt = nxt_on1[state_q];
    end else begin
      state_nxt = nxt_on0[state_q];
    end
  end

  // Moore output. It decodes the state only, with no path from i_x.
  always_comb begin
    o_seq_detected = 1'b0;
    if (state_q == S_DET) o_seq_detected = 1'b1;
  end

endmodule

// File: tb/tb_moore_nonoverlap_seq_detector.sv
// Bench for moore_nonoverlap_seq_detector. Two instances receive the same
// stimulus: the default pattern 1100 and an override of 1010. Each output is
// checked against a window-matching reference model. Directed steps also
// carry hand-derived constants.
module tb_moore_nonoverlap_seq_detector;

  logic clk = 1'b0;
  logic rst;
  logic x;
  logic det_a;
  logic det_b;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: recent bits, plus the count of bits usable by the next
  // match. That count is cleared by reset and by each detection.
  logic [15:0] hist_a, hist_b;
  int          avail_a, avail_b;
  logic        exp_a, exp_b;

  moore_nonoverlap_seq_detector u_dut_a (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_x            (x),
    .o_seq_detected (det_a)
  );

  moore_nonoverlap_seq_detector #(
    .SEQ_LEN (4),
    .SEQ     (4'b1010)
  ) u_dut_b (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_x            (x),
    .o_seq_detected (det_b)
  );

  always #5 clk = ~clk;

  // A detection occurs when the newest len bits equal the pattern and none of
  // them belongs to an earlier match.
  task automatic model_bit(input logic [15:0] pat, input int len, input logic r,
                           input logic b, inout logic [15:0] hist,
                           inout int avail, output logic det);
    logic [15:0] mask;
    mask = 16'((32'd1 << len) - 1);
    if (r) begin
      hist  = '0;
      avail = 0;
      det   = 1'b0;
    end else begin
      hist  = {hist[14:0], b};
      avail = avail + 1;
      det   = (avail >= len) && ((hist & mask) == (pat & mask));
      if (det) avail = 0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising
  // edge, then compare both instances with the model.
  task automatic step(input logic r, input logic b, input string tag);
    @(negedge clk);
    rst = r;
    x   = b;
    @(posedge clk);
    #1;
    n_vec++;
    model_bit(16'b1100, 4, r, b, hist_a, avail_a, exp_a);
    model_bit(16'b1010, 4, r, b, hist_b, avail_b, exp_b);
    chk({tag, "_a"}, det_a, exp_a);
    chk({tag, "_b"}, det_b, exp_b);
  endtask

  // Drives a bit string given MSB-first. After each bit, instance A is
  // compared against the matching bit of the expected pulse string.
  task automatic seq_a(input int n, input logic [15:0] bits,
                       input logic [15:0] pulses, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i], tag);
      chk({tag, "_const_a"}, det_a, pulses[i]);
    end
  endtask

  task automatic seq_b(input int n, input logic [15:0] bits,
                       input logic [15:0] pulses, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i], tag);
      chk({tag, "_const_b"}, det_b, pulses[i]);
    end
  endtask

  initial begin
    logic prev_a;
    logic prev_b;
    rst     = 1'b1;
    x       = 1'b0;
    hist_a  = '0;
    hist_b  = '0;
    avail_a = 0;
    avail_b = 0;

    // Reset held for two edges with arbitrary data.
    step(1'b1, 1'($urandom), "reset0");
    step(1'b1, 1'($urandom), "reset1");
    chk("reset_a", det_a, 1'b0);
    chk("reset_b", det_b, 1'b0);

    // Idle zeros after release.
    seq_a(3, 16'b000, 16'b000, "idle0");

    // Basic match, then the pulse must drop.
    seq_a(5, 16'b11000, 16'b00010, "basic");

    // Partial-match recovery.
    seq_a(5, 16'b11100, 16'b00001, "recov1");
    seq_a(6, 16'b101100, 16'b000001, "recov2");

    // Non-overlap on the 1010 instance, each run from a clean reset.
    step(1'b1, 1'b0, "rst_no1");
    seq_b(6, 16'b101010, 16'b000100, "nonov6");
    step(1'b1, 1'b0, "rst_no2");
    seq_b(8, 16'b10101010, 16'b00010001, "nonov8");

    // Reset mid-match discards the partial match.
    step(1'b1, 1'b0, "rst_mm0");
    seq_a(3, 16'b110, 16'b000, "midm_pre");
    step(1'b1, 1'b0, "midm_rst");
    chk("midm_rst_const_a", det_a, 1'b0);
    seq_a(1, 16'b0, 16'b0, "midm_post");
    seq_a(4, 16'b1100, 16'b0001, "midm_again");

    // Continuous stream: three pulses spaced four cycles apart.
    seq_a(12, 16'b110011001100, 16'b000100010001, "stream");

    // Randomized traffic with occasional resets. This also checks that the
    // output is never high for two consecutive cycles.
    prev_a = det_a;
    prev_b = det_b;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom), "rand");
      chk("pulse_width_a", prev_a & det_a, 1'b0);
      chk("pulse_width_b", prev_b & det_b, 1'b0);
      prev_a = det_a;
      prev_b = det_b;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
